// File: rtl/syncword_correlator.sv
// BR/EDR access-code detector: slides rxbit past the 64-bit sync word, counts mismatches, declares sync.
// Define PREAMBLE_CHECK_EN to widen the correlator to 68 bits and include the 4-bit preamble in the count.
module syncword_correlator #(
   parameter int WIN_W = 12,
   parameter int ERR_W = 7
) (
   input  logic             clk_6M,
   input  logic             rstz,
   input  logic             p_1us,
   input  logic             rxbit,
   input  logic             srch_start_p,
   input  logic             srch_stop,
   input  logic             pkt_end_p,
   input  logic [63:0]      syncword,
   input  logic [ERR_W-1:0] regi_corr_threshold,
   input  logic [WIN_W-1:0] regi_search_win,
   output logic             sync_found_p,
   output logic             rx_trailer_st_p,
   output logic             search_timeout_p,
   output logic [ERR_W-1:0] corr_errcnt,
   output logic             rx_locked,
   output logic             searching
);

`ifdef PREAMBLE_CHECK_EN
   localparam int SR_W = 68;
`else
   localparam int SR_W = 64;
`endif
   localparam logic [6:0] FILL_FULL = 7'(SR_W);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SEARCH = 2'd1;
   localparam logic [1:0] ST_LOCKED = 2'd2;

   function automatic logic [ERR_W-1:0] popcount(input logic [SR_W-1:0] v);
      logic [ERR_W-1:0] n;
      n = {ERR_W{1'b0}};
      for (int i = 0; i < SR_W; i++) begin
         n = n + ERR_W'(v[i]);
      end
      return n;
   endfunction

   logic [1:0]       state_q, state_d;
   logic [SR_W-1:0]  sr_q, sr_d;
   logic [6:0]       fill_q, fill_d;
   logic [WIN_W-1:0] win_q, win_d;
   logic [ERR_W-1:0] best_q, best_d;
   logic             eval_q, eval_d;
   logic             pend_q, pend_d;
   logic             found_q, found_d;
   logic             tout_q, tout_d;
   logic [ERR_W-1:0] errcnt_q, errcnt_d;
   logic             locked_q, locked_d;
   logic             srch_q, srch_d;

   logic [SR_W-1:0]  ref_s;
   logic [ERR_W-1:0] mism_s;
   logic [ERR_W-1:0] best_now_s;
   logic             full_s;
   logic             hit_s;
   logic             expire_s;

`ifdef PREAMBLE_CHECK_EN
   // Preamble alternates and its last bit is the complement of the first sync bit.
   assign ref_s = {(syncword[63] ? 4'b1010 : 4'b0101), syncword};
`else
   assign ref_s = syncword;
`endif

   assign mism_s     = popcount(sr_q ^ ref_s);
   assign full_s     = (fill_q == FILL_FULL);
   assign hit_s      = eval_q && full_s && (mism_s <= regi_corr_threshold);
   assign expire_s   = (regi_search_win != {WIN_W{1'b0}}) && (win_q == {WIN_W{1'b0}});
   assign best_now_s = (full_s && (mism_s < best_q)) ? mism_s : best_q;

   always_comb begin
      state_d  = state_q;
      sr_d     = sr_q;
      fill_d   = fill_q;
      win_d    = win_q;
      best_d   = best_q;
      eval_d   = 1'b0;
      pend_d   = pend_q & ~p_1us;
      found_d  = 1'b0;
      tout_d   = 1'b0;
      errcnt_d = errcnt_q;
      locked_d = locked_q;
      if (srch_stop) begin
         state_d  = ST_IDLE;
         pend_d   = 1'b0;
         locked_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (srch_start_p) begin
                  state_d = ST_SEARCH;
                  fill_d  = 7'd0;
                  win_d   = regi_search_win;
                  best_d  = {ERR_W{1'b1}};
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_SEARCH: begin
               if (srch_start_p) begin
                  fill_d = 7'd0;
                  win_d  = regi_search_win;
                  best_d = {ERR_W{1'b1}};
               end else begin
                  if (p_1us) begin
                     sr_d   = {sr_q[SR_W-2:0], rxbit};
                     fill_d = full_s ? fill_q : fill_q + 7'd1;
                     win_d  = (win_q != {WIN_W{1'b0}}) ? win_q - WIN_W'(1) : win_q;
                     eval_d = 1'b1;
                  end else begin
                     eval_d = 1'b0;
                  end
                  // Evaluation runs one clock after the shift so the popcount sees the new bit.
                  if (eval_q) begin
                     best_d = best_now_s;
                     if (hit_s) begin
                        found_d  = 1'b1;
                        errcnt_d = mism_s;
                        locked_d = 1'b1;
                        pend_d   = 1'b1;
                        state_d  = ST_LOCKED;
                     end else if (expire_s) begin
                        tout_d   = 1'b1;
                        errcnt_d = best_now_s;
                        state_d  = ST_IDLE;
                     end else begin
                        state_d = ST_SEARCH;
                     end
                  end else begin
                     best_d = best_q;
                  end
               end
            end
            ST_LOCKED: begin
               if (pkt_end_p) begin
                  state_d  = ST_IDLE;
                  locked_d = 1'b0;
                  pend_d   = 1'b0;
               end else begin
                  state_d = ST_LOCKED;
               end
            end
            default: begin
               state_d  = ST_IDLE;
               locked_d = 1'b0;
               pend_d   = 1'b0;
            end
         endcase
      end
      srch_d = (state_d == ST_SEARCH);
   end

   always_ff @(posedge clk_6M or negedge rstz) begin
      if (!rstz) begin
         state_q  <= ST_IDLE;
         sr_q     <= {SR_W{1'b0}};
         fill_q   <= 7'd0;
         win_q    <= {WIN_W{1'b0}};
         best_q   <= {ERR_W{1'b1}};
         eval_q   <= 1'b0;
         pend_q   <= 1'b0;
         found_q  <= 1'b0;
         tout_q   <= 1'b0;
         errcnt_q <= {ERR_W{1'b1}};
         locked_q <= 1'b0;
         srch_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         sr_q     <= sr_d;
         fill_q   <= fill_d;
         win_q    <= win_d;
         best_q   <= best_d;
         eval_q   <= eval_d;
         pend_q   <= pend_d;
         found_q  <= found_d;
         tout_q   <= tout_d;
         errcnt_q <= errcnt_d;
         locked_q <= locked_d;
         srch_q   <= srch_d;
      end
   end

   assign sync_found_p     = found_q;
   assign search_timeout_p = tout_q;
   assign corr_errcnt      = errcnt_q;
   assign rx_locked        = locked_q;
   assign searching        = srch_q;
   assign rx_trailer_st_p  = pend_q & p_1us & ~srch_stop;

endmodule
